gen_step_ctrl: RTL and testbench
================================

# gen_step_ctrl

Consumer side of the generation clock. Takes the one-cycle `tick` strobe from the rate-selectable strobe generator, plus a single-step button, and turns each request into a start/done handshake with the cellular-automaton update core. After each completed generation it issues a buffer swap pulse and counts generations. It also flags requests lost to overrun and cores that never answer.

## Interface
- `CNT_W`, default 16: width of the generation counter.
- `TIMEOUT`, default 1023: maximum WAIT cycles before abandoning a generation; legal range 1 to 2^16-1.
- `clk` input 1: system clock; one clock domain; everything is rising-edge.
- `rst` input 1: reset; asynchronous, active-high.
- `tick` input 1: one-cycle request strobe from the strobe generator; held low in stop mode.
- `step_btn` input 1: raw single-step button; asynchronous level; synchronised internally.
- `ca_done` input 1: one-cycle completion pulse from the CA core.
- `clr_count` input 1: synchronous clear of `gen_count`, `overrun` and `timeout`.
- `ca_start` output 1: one-cycle start pulse to the CA core.
- `ca_swap` output 1: one-cycle pulse that swaps the ping-pong generation buffers.
- `busy` output 1: high in START, WAIT and SWAP.
- `gen_count` output CNT_W: number of completed generations; wraps modulo 2^CNT_W.
- `overrun` output 1: sticky; set when a request is dropped.
- `timeout` output 1: sticky; set when a generation is abandoned.

## Operation
- **Step synchroniser:** two-flop synchroniser on `step_btn`, then a rising-edge detector that produces a one-cycle `step_req`. Holding the button produces exactly one request.
- **Request:** `req = tick | step_req`.
- **Pending register (one deep):**
  - A `req` arriving while `busy`, or in the same cycle IDLE launches another request, sets `pending`.
  - A `req` arriving while `pending` is already set is dropped and sets `overrun`.
- **FSM states:** IDLE, START, WAIT, SWAP.
  - IDLE -> START when `req` or `pending` is set. `pending` clears on this transition; `pending` has priority.
  - START: `ca_start` = 1 for this single cycle. Clear the wait counter. -> WAIT.
  - WAIT: on `ca_done` -> SWAP. Otherwise, when the wait counter reaches TIMEOUT -> IDLE, set `timeout`, no swap, no count.
  - SWAP: `ca_swap` = 1 for this single cycle. `gen_count` increments by 1 (all ones wraps to 0). -> IDLE.
- `ca_done` outside WAIT is ignored.
- `ca_done` in the same cycle the counter reaches TIMEOUT counts as done; no timeout.
- `clr_count` has priority over a coincident increment or flag set; result is 0.
- `clr_count` does not affect the FSM or `pending`.
- All outputs are registered or decoded directly from the state register; no input-to-output combinational paths.

## Timing
- **Reset values:** state = IDLE, `ca_start` = 0, `ca_swap` = 0, `busy` = 0, `gen_count` = 0, `overrun` = 0, `timeout` = 0, `pending` = 0, synchroniser flops = 0.
- **Reset mid-operation:** immediate return to the above. An in-flight generation is discarded without a swap.
- **Start latency:** `tick` high in cycle n (FSM in IDLE) -> START / `ca_start` in cycle n+1, WAIT from n+2.
- **Completion:** `ca_done` in WAIT cycle m -> SWAP / `ca_swap` in m+1, new `gen_count` visible from m+2, IDLE in m+2.
- **Back-to-back:** with `pending` set, START follows in m+3. Minimum request period is 4 cycles plus core latency.
- **Step latency:** `step_btn` rising before edge k -> `step_req` in cycle k+2 -> START in k+3.
- **Timeout:** with WAIT entered in cycle w and no `ca_done`, `timeout` is set and the FSM is in IDLE at cycle w+TIMEOUT+1.

## Test plan
- **Single tick:** reset, `tick` pulse at cycle 10, `ca_done` at cycle 15 -> `ca_start` at 11, `ca_swap` at 16, `gen_count` = 1 from 17, `busy` low from 17.
- **Pending and overrun:** ticks at cycles 10, 12 and 13, `ca_done` 5 cycles after each start -> two generations, `gen_count` = 2, `overrun` = 1, exactly two `ca_start` pulses.
- **Step button:** `step_btn` held high for 50 cycles with fast `ca_done` -> exactly one generation. Release and press again -> `gen_count` = 2.
- **Timeout:** TIMEOUT = 8, `tick` with no `ca_done` -> `timeout` = 1, no `ca_swap`, `gen_count` unchanged, and the next tick starts normally.
- **Wrap and clear:** CNT_W = 4, 16 generations -> `gen_count` wraps to 0. `clr_count` coincident with a SWAP -> `gen_count` = 0, flags cleared.
- **Reset in WAIT:** assert `rst` during WAIT, then `ca_done` after release -> no `ca_swap`, all outputs at reset values.

Source files
------------

// File: rtl/gen_step_ctrl.sv
// Generation step controller: turns strobe ticks and single-step presses into
// start/done handshakes with the CA core, then swaps buffers and counts generations.
module gen_step_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             step_btn,
  input  logic             ca_done,
  input  logic             clr_count,
  output logic             ca_start,
  output logic             ca_swap,
  output logic             busy,
  output logic [CNT_W-1:0] gen_count,
  output logic             overrun,
  output logic             timeout
);

  localparam logic [15:0] TO_VAL = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, WAIT, SWAP} state_t;

  state_t      state, state_nxt;
  logic [2:0]  sync_q;
  logic        step_req;
  logic        req;
  logic        pending, pending_nxt;
  logic        ovr_set, to_hit;
  logic [15:0] wait_cnt;

  // sync_q[1] is the synchronised level; sync_q[2] is its previous value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      step_req <= 1'b0;
    end else begin
      sync_q   <= {sync_q[1:0], step_btn};
      step_req <= sync_q[1] & ~sync_q[2];
    end
  end

  assign req = tick | step_req;

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    ovr_set     = 1'b0;
    to_hit      = 1'b0;
    case (state)
      IDLE: begin
        if (pending || req) begin
          state_nxt = START;
          // a pending launch leaves a coincident req queued behind it
          pending_nxt = pending & req;
        end
      end
      START: state_nxt = WAIT;
      WAIT: begin
        if (ca_done) begin
          state_nxt = SWAP;
        end else if (wait_cnt == TO_VAL) begin
          state_nxt = IDLE;
          to_hit    = 1'b1;
        end
      end
      SWAP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && req) begin
      if (pending) ovr_set = 1'b1;
      else         pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      if (state == START)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_count <= '0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else if (clr_count) begin
      gen_count <= '0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      if (state == SWAP) gen_count <= gen_count + 1'b1;
      if (ovr_set)       overrun   <= 1'b1;
      if (to_hit)        timeout   <= 1'b1;
    end
  end

  assign ca_start = (state == START);
  assign ca_swap  = (state == SWAP);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_gen_step_ctrl.sv
// Directed bench for gen_step_ctrl with small counter and short timeout.
module tb_gen_step_ctrl;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             rst, tick, step_btn, ca_done, clr_count;
  logic             ca_start, ca_swap, busy, overrun, timeout;
  logic [CNT_W-1:0] gen_count;

  int total = 0, bad = 0;
  int n_start = 0, n_swap = 0;
  int bs, bw;

  gen_step_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .tick(tick), .step_btn(step_btn), .ca_done(ca_done),
    .clr_count(clr_count), .ca_start(ca_start), .ca_swap(ca_swap), .busy(busy),
    .gen_count(gen_count), .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ca_start === 1'b1) n_start++;
    if (ca_swap === 1'b1)  n_swap++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; tick = 1'b0; step_btn = 1'b0; ca_done = 1'b0; clr_count = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  initial begin
    do_reset();
    chk("rst_start", 32'(ca_start), 0);
    chk("rst_swap", 32'(ca_swap), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gen", 32'(gen_count), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_to", 32'(timeout), 0);
    cyc(6);
    chk("rst_idle_stays", 32'(busy), 0);

    // single tick: tick in cycle 10, done in cycle 15
    tick = 1'b1; cyc(1); tick = 1'b0;
    chk("t1_start", 32'(ca_start), 1);
    chk("t1_busy", 32'(busy), 1);
    cyc(1);
    chk("t1_start_once", 32'(ca_start), 0);
    cyc(3);
    ca_done = 1'b1; cyc(1); ca_done = 1'b0;
    chk("t1_swap", 32'(ca_swap), 1);
    chk("t1_gen_old", 32'(gen_count), 0);
    cyc(1);
    chk("t1_gen", 32'(gen_count), 1);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_swap_once", 32'(ca_swap), 0);

    // pending and overrun
    do_reset();
    bs = n_start; bw = n_swap;
    for (int c = 0; c < 25; c++) begin
      tick    = (c == 0 || c == 2 || c == 3);
      ca_done = (c == 6 || c == 14);
      cyc(1);
    end
    tick = 1'b0; ca_done = 1'b0;
    cyc(2);
    chk("po_gen", 32'(gen_count), 2);
    chk("po_ovr", 32'(overrun), 1);
    chk("po_starts", n_start - bs, 2);
    chk("po_swaps", n_swap - bw, 2);
    chk("po_to", 32'(timeout), 0);
    chk("po_idle", 32'(busy), 0);
    clr_count = 1'b1; cyc(1); clr_count = 1'b0;
    chk("clr_gen", 32'(gen_count), 0);
    chk("clr_ovr", 32'(overrun), 0);

    // step button held, then pressed again
    do_reset();
    ca_done = 1'b1;
    bs = n_start;
    step_btn = 1'b1;
    cyc(3);
    chk("st_lat_early", 32'(ca_start), 0);
    cyc(1);
    chk("st_lat", 32'(ca_start), 1);
    cyc(46);
    chk("st_hold_starts", n_start - bs, 1);
    chk("st_hold_gen", 32'(gen_count), 1);
    step_btn = 1'b0; cyc(10);
    step_btn = 1'b1; cyc(20);
    step_btn = 1'b0; cyc(5);
    chk("st_again_gen", 32'(gen_count), 2);
    chk("st_again_starts", n_start - bs, 2);

    // timeout
    do_reset();
    bw = n_swap;
    tick = 1'b1; cyc(1); tick = 1'b0;
    cyc(9);
    chk("to_still_wait", 32'(busy), 1);
    chk("to_not_yet", 32'(timeout), 0);
    cyc(1);
    chk("to_flag", 32'(timeout), 1);
    chk("to_idle", 32'(busy), 0);
    chk("to_gen", 32'(gen_count), 0);
    chk("to_noswap", n_swap - bw, 0);
    ca_done = 1'b1;
    tick = 1'b1; cyc(1); tick = 1'b0;
    chk("to_next_start", 32'(ca_start), 1);
    cyc(4);
    chk("to_next_gen", 32'(gen_count), 1);

    // done on the last WAIT cycle wins over timeout
    clr_count = 1'b1; cyc(1); clr_count = 1'b0;
    ca_done = 1'b0;
    tick = 1'b1; cyc(1); tick = 1'b0;
    cyc(9);
    ca_done = 1'b1; cyc(1); ca_done = 1'b0;
    chk("edge_swap", 32'(ca_swap), 1);
    chk("edge_no_to", 32'(timeout), 0);
    cyc(1);
    chk("edge_gen", 32'(gen_count), 1);
    chk("edge_no_to2", 32'(timeout), 0);

    // wrap at CNT_W = 4
    do_reset();
    bw = n_swap;
    ca_done = 1'b1;
    repeat (15) begin
      tick = 1'b1; cyc(1); tick = 1'b0; cyc(5);
    end
    chk("wr_15", 32'(gen_count), 15);
    tick = 1'b1; cyc(1); tick = 1'b0; cyc(5);
    chk("wr_wrap", 32'(gen_count), 0);
    chk("wr_swaps", n_swap - bw, 16);
    tick = 1'b1; cyc(1); tick = 1'b0; cyc(5);
    chk("wr_one", 32'(gen_count), 1);

    // build both flags, then clear coincident with a SWAP
    ca_done = 1'b0;
    for (int c = 0; c < 31; c++) begin
      tick = (c == 0 || c == 2 || c == 3);
      cyc(1);
    end
    tick = 1'b0;
    chk("fl_ovr", 32'(overrun), 1);
    chk("fl_to", 32'(timeout), 1);
    chk("fl_gen", 32'(gen_count), 1);
    ca_done = 1'b1;
    tick = 1'b1; cyc(1); tick = 1'b0;
    cyc(2);
    chk("cc_swap", 32'(ca_swap), 1);
    clr_count = 1'b1; cyc(1); clr_count = 1'b0;
    chk("cc_gen", 32'(gen_count), 0);
    chk("cc_ovr", 32'(overrun), 0);
    chk("cc_to", 32'(timeout), 0);
    chk("cc_idle", 32'(busy), 0);

    // reset while in WAIT
    do_reset();
    tick = 1'b1; cyc(1); tick = 1'b0;
    cyc(2);
    chk("rw_wait", 32'(busy), 1);
    bw = n_swap; bs = n_start;
    rst = 1'b1; #2;
    chk("rw_async", 32'(busy), 0);
    cyc(2);
    rst = 1'b0;
    ca_done = 1'b1; cyc(1); ca_done = 1'b0;
    cyc(3);
    chk("rw_noswap", n_swap - bw, 0);
    chk("rw_nostart", n_start - bs, 0);
    chk("rw_busy", 32'(busy), 0);
    chk("rw_gen", 32'(gen_count), 0);
    chk("rw_flags", 32'({overrun, timeout}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
